// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader: state
// encodings, default limits and state-class helpers.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam int DEF_MAX_WORDS      = 256;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // States in which a stream byte may be taken.
  function automatic logic takes_bytes(state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
           (s == DATA_LO) || (s == CHECK);
  endfunction

  // Once a frame has started, gaps between bytes are policed.
  function automatic logic can_time_out(state_t s);
    return (s == LEN_LO) || (s == DATA_HI) || (s == DATA_LO) || (s == CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle counter; o_expired fires during the idle cycle that makes
// TIMEOUT_CYCLES consecutive idle cycles. TIMEOUT_CYCLES = 0 disables it.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && (r_cnt == LAST);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte frame into 16-bit
// big-endian words, writes them to instruction memory, then releases the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter int          MAX_WORDS      = DEF_MAX_WORDS,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        proc_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] word_count
);

  localparam logic [31:0] MAXW = 32'(MAX_WORDS);

  state_t      r_state;
  logic [7:0]  r_len_hi;
  logic [15:0] r_len;
  logic [15:0] r_idx;
  logic [7:0]  r_hi;
  logic [7:0]  r_sum;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_proc_reset;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_wcount;

  logic        w_ready;
  logic        w_accept;
  logic [15:0] w_len;
  logic [15:0] w_idx_next;
  logic        w_to_clear;
  logic        w_to_en;
  logic        w_expired;

  assign w_ready    = !reset && takes_bytes(r_state);
  assign w_accept   = byte_valid && w_ready;
  assign w_len      = {r_len_hi, byte_data};
  assign w_idx_next = r_idx + 16'd1;
  assign w_to_clear = w_accept || !can_time_out(r_state);
  assign w_to_en    = can_time_out(r_state) && !w_accept;

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_to_clear),
    .i_enable (w_to_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= LEN_HI;
      r_len_hi     <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_hi         <= '0;
      r_sum        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_proc_reset <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_wcount     <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_expired) begin
        r_state <= ERR;
        r_err   <= 1'b1;
      end else if (w_accept) begin
        // The checksum byte itself is not part of the running sum.
        if (r_state != CHECK) r_sum <= r_sum + byte_data;
        case (r_state)
          LEN_HI: begin
            r_len_hi <= byte_data;
            r_state  <= LEN_LO;
          end
          LEN_LO: begin
            r_len <= w_len;
            r_idx <= '0;
            if ({16'h0000, w_len} > MAXW) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else if (w_len == 16'd0) begin
              r_state <= CHECK;
            end else begin
              r_state <= DATA_HI;
            end
          end
          DATA_HI: begin
            r_hi    <= byte_data;
            r_state <= DATA_LO;
          end
          DATA_LO: begin
            r_we     <= 1'b1;
            r_addr   <= BASE_ADDR + r_idx;
            r_wdata  <= {r_hi, byte_data};
            r_wcount <= w_idx_next;
            r_idx    <= w_idx_next;
            r_state  <= (w_idx_next == r_len) ? CHECK : DATA_HI;
          end
          CHECK: begin
            if (byte_data == r_sum) begin
              r_state      <= DONE;
              r_done       <= 1'b1;
              r_proc_reset <= 1'b0;
            end else begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (reload && ((r_state == DONE) || (r_state == ERR))) begin
        r_state      <= LEN_HI;
        r_proc_reset <= 1'b1;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
        r_wcount     <= '0;
        r_sum        <= '0;
        r_idx        <= '0;
      end
    end
  end

  assign byte_ready = w_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign proc_reset = r_proc_reset;
  assign load_done  = r_done;
  assign load_err   = r_err;
  assign word_count = r_wcount;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time instruction-memory loader that sits directly upstream of the pipelined processor core.
- Receives a framed byte stream through a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Writes each word into instruction memory starting at BASE_ADDR.
- Holds the core in reset (proc_reset) until a complete frame with a valid checksum has been loaded; a failed load leaves the core held in reset.

Parameters:
- BASE_ADDR, 16'h0000, instruction-memory address of word 0.
- MAX_WORDS, 256, largest legal word count; any larger length is an error.
- TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- reload  in  1  one-cycle pulse; restarts loading from DONE or ERR
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  16  instruction-memory write address
- imem_wdata  out  16  instruction word to write
- proc_reset  out  1  held-reset output to the core
- load_done  out  1  frame loaded and checksum correct
- load_err  out  1  length, checksum or timeout error
- word_count  out  16  number of words written in the current load

Behaviour:
- Reset is synchronous and active-high. While reset is high:
  - state = LEN_HI
  - byte_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0
  - proc_reset = 1, load_done = 0, load_err = 0, word_count = 0
  - the checksum and timeout counters are cleared
- Frame format: LEN_HI, LEN_LO, then LEN words sent high byte first, then one checksum byte.
  - checksum = 8-bit wrapping sum of every byte before it, including both length bytes.
- A byte is accepted only when byte_valid && byte_ready.
  - byte_ready is combinational: it is 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK, and 0 in DONE, ERR, or while reset is high.
  - There is no back-pressure inside a frame.
- State transitions on an accepted byte:
  - LEN_HI -> LEN_LO.
  - LEN_LO: if LEN > MAX_WORDS -> ERR; if LEN == 0 -> CHECK; otherwise -> DATA_HI.
  - DATA_HI -> DATA_LO, latching the high byte.
  - DATA_LO -> DATA_HI, or -> CHECK when this is the last word.
  - CHECK: if the received byte equals the running sum -> DONE, otherwise -> ERR.
- Write timing:
  - imem_we is a single-cycle pulse registered on the cycle after the DATA_LO byte is accepted.
  - On that cycle imem_addr = BASE_ADDR + word index (16-bit wrap) and imem_wdata = {hi, lo}.
  - word_count increments on the same edge as the pulse.
- DONE: proc_reset = 0 and load_done = 1, both registered, taking effect the cycle after the checksum byte is accepted. If imem_we for the final word is still pending, it completes first or concurrently.
- ERR: load_err = 1, proc_reset stays 1, and all further bytes are refused.
- reload:
  - In DONE or ERR, a reload pulse goes to LEN_HI and sets proc_reset = 1. It also clears load_done, load_err, word_count and the checksum.
  - In any other state, reload is ignored.
- Timeout: in LEN_LO, DATA_HI, DATA_LO or CHECK, the idle counter increments on every cycle without an accepted byte and clears on an accepted byte. Reaching TIMEOUT_CYCLES moves the loader to ERR. LEN_HI never times out.
- Reset in the middle of a load aborts it immediately:
  - no further writes occur;
  - memory already written is left as it is;
  - the loader restarts at LEN_HI with proc_reset = 1.
- Priority order: reset > timeout > byte acceptance > reload.

Decomposition:
- Shared include file (imem_loader_defs) holds:
  - the state encodings LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR;
  - the default MAX_WORDS and TIMEOUT_CYCLES constants.
- One sub-module, loader_timeout: the idle counter, with inputs clear and enable and output expired.
- The FSM, word assembly and checksum stay in imem_loader.

Test Plan:
- Nominal load: bytes 00 02 12 34 AB CD C0 with byte_valid held high.
  - imem_we pulses at addr 0x0000 with data 0x1234, and at addr 0x0001 with data 0xABCD.
  - Then load_done = 1, proc_reset = 0, word_count = 2.
- Bad checksum: same frame ending in C1 instead of C0.
  - Both writes occur, then load_err = 1 with proc_reset = 1.
  - A following reload pulse returns byte_ready = 1 and clears load_err.
- Zero-length frame: bytes 00 00 00.
  - No imem_we pulse; load_done = 1, word_count = 0.
- Oversize frame: bytes 01 01 (LEN 257).
  - load_err = 1 on the cycle after LEN_LO; byte_ready = 0 afterwards.
- Timeout: TIMEOUT_CYCLES = 8, send 00 01 12 and then stop.
  - ERR is reached exactly 8 idle cycles after byte 12; no write occurs.
- Gappy stream and reset mid-load:
  - Nominal frame with random 0-5 cycle gaps between bytes gives results identical to the nominal load.
  - Asserting reset after the first write gives proc_reset = 1 and state LEN_HI.
  - A fresh frame sent afterwards then loads correctly.
